// File: rtl/re_empty_if.sv
// re_empty_if: read-side pointer/status bundle between the read controller, the write domain and re_empty_gen.
interface re_empty_if #(parameter int DEPTH = 32);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] rcntr_i;
  logic [AW:0] wgray_i;
  logic [AW:0] rgray_o;
  logic        empty_o;
  logic [AW:0] rlevel_o;
`ifdef RE_ALMOST_EMPTY_EN
  logic        almost_empty_o;
  modport master (output rcntr_i, wgray_i, input rgray_o, empty_o, rlevel_o, almost_empty_o);
  modport slave (input rcntr_i, wgray_i, output rgray_o, empty_o, rlevel_o, almost_empty_o);
`else
  modport master (output rcntr_i, wgray_i, input rgray_o, empty_o, rlevel_o);
  modport slave (input rcntr_i, wgray_i, output rgray_o, empty_o, rlevel_o);
`endif
endinterface

// File: rtl/re_empty_gen.sv
// re_empty_gen: async FIFO read-side Gray export, write-pointer sync, empty/level (almost-empty with RE_ALMOST_EMPTY_EN).
module re_empty_gen #(
  parameter int DEPTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 4
) (
  input logic rclk,
  input logic rst,
  re_empty_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] r_rgray;
  logic [AW:0] r_wsync [SYNC_STAGES];
  logic [AW:0] w_rgray_n;
  logic [AW:0] w_wgray_s;
  logic [AW:0] w_wbin;
  assign w_rgray_n = bus.rcntr_i ^ (bus.rcntr_i >> 1);
  assign w_wgray_s = r_wsync[SYNC_STAGES-1];
  always_ff @(posedge rclk) begin
    if (rst) begin
      r_rgray <= '0;
      for (int k = 0; k < SYNC_STAGES; k++) r_wsync[k] <= '0;
    end else begin
      r_rgray <= w_rgray_n;
      r_wsync[0] <= bus.wgray_i;
      for (int k = 1; k < SYNC_STAGES; k++) r_wsync[k] <= r_wsync[k-1];
    end
  end
  for (genvar g = 0; g <= AW; g++) begin : g_g2b
    assign w_wbin[g] = ^(w_wgray_s >> g);
  end
  assign bus.rgray_o  = r_rgray;
  assign bus.empty_o  = w_wgray_s == w_rgray_n;
  assign bus.rlevel_o = w_wbin - bus.rcntr_i;
`ifdef RE_ALMOST_EMPTY_EN
  assign bus.almost_empty_o = bus.rlevel_o <= (AW+1)'(AE_THRESH);
`endif
endmodule

// File: doc/re_empty_gen.md
# re_empty_gen

Read-domain pointer/status stage of the async FIFO. Takes the binary read counter from the read controller, publishes it as a registered Gray pointer for the write domain, and synchronizes the write domain's Gray pointer into `rclk`. From these it produces the `empty` flag consumed by the read controller, a read-side occupancy count, and an optional almost-empty flag. All logic runs on the single `rclk` domain; only `wgray_i` arrives asynchronously.

## Interface

Parameters:
- `DEPTH`, default 32: FIFO depth; power of two, ≥ 2. `AW = $clog2(DEPTH)`.
- `SYNC_STAGES`, default 2: flop stages on `wgray_i`; ≥ 2.
- `AE_THRESH`, default 4: almost-empty threshold in entries; 0 ≤ `AE_THRESH` < `DEPTH`.

Ports:
- `rclk`, input, 1: read-domain clock. One clock only.
- `rst`, input, 1: reset. Synchronous and active-high.
- `rcntr_i`, input, `AW+1`: binary read counter, including the wrap bit, from the read controller.
- `wgray_i`, input, `AW+1`: Gray-coded write pointer. Asynchronous to `rclk`.
- `rgray_o`, output, `AW+1`: registered Gray encoding of `rcntr_i`, sent to the write domain.
- `empty_o`, output, 1: FIFO empty, as seen by the read side.
- `rlevel_o`, output, `AW+1`: read-side occupancy, 0..`DEPTH`.
- `almost_empty_o`, output, 1: occupancy ≤ `AE_THRESH`. Present only with the macro.

## Operation

- **Gray export.** `rgray_o <= rcntr_i ^ (rcntr_i >> 1)` every cycle. This is a single register; no combinational path leaves the block toward the write domain.
- **Write-pointer sync.** `wgray_i` passes through a shift chain of `SYNC_STAGES` flops, `wsync[0..SYNC_STAGES-1]`. `wgray_s` is the last stage. No logic is placed between stages.
- **Gray to binary.** `wbin_s[AW] = wgray_s[AW]`. For each lower bit `i`, `wbin_s[i] = wbin_s[i+1] ^ wgray_s[i]`. This is combinational from the `wgray_s` register.
- **Empty flag.** `empty_o = (wgray_s == bin2gray(rcntr_i))`.
  - It is combinational from `rcntr_i` and `wgray_s`, both of which are registers.
  - There is no added latency, so `empty_o` reflects a read in the same cycle that `rcntr_i` advances. The read controller therefore cannot over-read.
- **Level.** `rlevel_o = (wbin_s - rcntr_i)`, computed modulo 2^(AW+1) at width `AW+1`.
  - The wrap bit makes the difference correct across counter wrap-around.
  - The value is pessimistic by up to `SYNC_STAGES`+1 write-side cycles of stale writes. It is never larger than the true occupancy.
- **Boundary conditions.**
  - Equal pointers give `empty_o=1` and `rlevel_o=0`.
  - Pointers differing only in the MSB are full: `rlevel_o = DEPTH`, `empty_o=0`.
  - A stale synchronized pointer can only delay the deassertion of `empty_o`. It can never delay its assertion.
- **Reset.**
  - All sync stages clear to 0 and `rgray_o` clears to 0.
  - With `rcntr_i=0`, this gives `empty_o=1` and `rlevel_o=0`.
  - Asserting `rst` mid-operation clears the sync chain on the next edge. `empty_o` then re-evaluates against whatever `rcntr_i` holds. System-level reset sequencing keeps `rcntr_i` and the write side consistent; this block does not police it.

## Timing

- Reset values: `rgray_o=0`, `wsync[*]=0`, `empty_o=1` (given `rcntr_i=0`), `rlevel_o=0`, `almost_empty_o=1`.
- `rcntr_i` to `rgray_o`: 1 cycle.
- `rcntr_i` to `empty_o`, `rlevel_o`, `almost_empty_o`: 0 cycles (combinational).
- `wgray_i` change to `empty_o` and `rlevel_o`: `SYNC_STAGES` `rclk` edges, plus up to one edge of sampling uncertainty.
- A write and a read in the same cycle:
  - the read takes effect immediately through `rcntr_i`;
  - the write becomes visible after the sync latency;
  - `empty_o` may assert transiently. This is a legal, conservative outcome.

## Configuration

- Macro `RE_ALMOST_EMPTY_EN`.
- **Defined:** `almost_empty_o = (rlevel_o <= AE_THRESH)`. It is combinational and is 1 while in reset or empty.
- **Undefined:** the `almost_empty_o` port and its comparator are not compiled. `rlevel_o` is still produced.

## Test plan

- **Reset.** Assert `rst` for 2 cycles with `rcntr_i=0` and `wgray_i=0` → `rgray_o=0`, `empty_o=1`, `rlevel_o=0`, `almost_empty_o=1`.
- **Sync latency.** With `DEPTH=32`, `SYNC_STAGES=2`, `rcntr_i=0`, step `wgray_i` from 0 to gray(3)=6'b000010 → `empty_o` stays 1 for exactly 2 edges, then `empty_o=0` and `rlevel_o=3`.
- **Drain to empty.** With the state above, step `rcntr_i` 0→1→2→3 one per cycle → `rlevel_o` 3,2,1,0. `empty_o` rises in the same cycle `rcntr_i=3`. `rgray_o` follows `rcntr_i` one cycle later.
- **Wrap and full.** Set `rcntr_i=6'd40` and synced `wgray_i=gray(8)` → `rlevel_o=32`, `empty_o=0`. Then set `rcntr_i=6'd8` → `rlevel_o=0`, `empty_o=1`.
- **Almost-empty (macro on, `AE_THRESH=4`).** Levels 5, 4, 0 → `almost_empty_o` = 0, 1, 1.
- **Mid-run reset.** With `rlevel_o=10`, pulse `rst` with `rcntr_i=0` → on the next edge the sync chain clears, `empty_o=1`, `rlevel_o=0`, and no X appears on any output.
